// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, 1 stop bit, mid-bit sampling.
// Received pulses one cycle per completed frame; errors are flagged alongside the byte.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  output logic [7:0] Dout,
  output logic       Received,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Busy
);
  localparam int BAUD_COUNT = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  localparam int TW         = $clog2(BAUD_COUNT);
  localparam logic [TW-1:0] BAUD_LAST = TW'(BAUD_COUNT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_COUNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            perr_q, perr_d;
  logic [7:0]      dout_q, dout_d;
  logic            rcv_q, rcv_d;
  logic            parerr_q, parerr_d;
  logic            frmerr_q, frmerr_d;
  logic            rx_s, tick, half;

  assign rx_s = sync_q[1];
  assign tick = (timer_q == BAUD_LAST);
  assign half = (timer_q == HALF_LAST);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      dout_q   <= '0;
      rcv_q    <= 1'b0;
      parerr_q <= 1'b0;
      frmerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      dout_q   <= dout_d;
      rcv_q    <= rcv_d;
      parerr_q <= parerr_d;
      frmerr_q <= frmerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (half) state_d = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_q == 3'd7) state_d = PARITY;
      PARITY:  if (tick) state_d = STOP;
      // a low stop bit may be a break; hold off until the line idles again
      STOP:    if (tick) state_d = rx_s ? IDLE : RECOVER;
      RECOVER: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d   = {sync_q[0], Sin};
    timer_d  = (state_d != state_q || state_q == IDLE || tick) ? '0 : timer_q + TW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    dout_d   = dout_q;
    rcv_d    = 1'b0;
    parerr_d = parerr_q;
    frmerr_d = frmerr_q;
    case (state_q)
      START:  bit_d = '0;
      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      PARITY: if (tick) perr_d = ~(^shift_q ^ rx_s);
      STOP: if (tick) begin
        rcv_d    = 1'b1;
        dout_d   = shift_q;
        parerr_d = perr_q;
        frmerr_d = ~rx_s;
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy      = (state_q != IDLE);
    Dout      = dout_q;
    Received  = rcv_q;
    ParityErr = parerr_q;
    FrameErr  = frmerr_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx using a short bit period (1000/60 -> 16 clocks per bit).
module tb_uart_rx;
  localparam int CLK_FREQUENCY = 1000;
  localparam int BAUD_RATE     = 60;
  localparam int B             = 16;
  localparam int H             = 8;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Sin = 1'b1;
  logic [7:0] Dout;
  logic       Received, ParityErr, FrameErr, Busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int start_cyc = 0;
  int base;
  logic [7:0] log_d [16];
  logic       log_pe[16];
  logic       log_fe[16];
  int         log_t [16];

  uart_rx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .Reset(Reset), .Sin(Sin), .Dout(Dout), .Received(Received),
    .ParityErr(ParityErr), .FrameErr(FrameErr), .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (Received === 1'b1) begin
      if (rx_cnt < 16) begin
        log_d[rx_cnt]  = Dout;
        log_pe[rx_cnt] = ParityErr;
        log_fe[rx_cnt] = FrameErr;
        log_t[rx_cnt]  = cyc;
      end
      rx_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    Sin = b;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(p);
    bit_time(s);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_dout"}, Dout, 8'h00);
    chk({tag, "_rcv"},  Received, 1'b0);
    chk({tag, "_pe"},   ParityErr, 1'b0);
    chk({tag, "_fe"},   FrameErr, 1'b0);
    chk({tag, "_busy"}, Busy, 1'b0);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    Reset = 1'b0;
    bit_time(1'b1);

    // 1: clean 0x41 (two ones -> parity bit 1)
    base = rx_cnt;
    send_frame(8'h41, 1'b1, 1'b1);
    bit_time(1'b1);
    chk("t1_cnt", rx_cnt, base + 1);
    chk("t1_dout", log_d[base], 8'h41);
    chk("t1_pe", log_pe[base], 1'b0);
    chk("t1_fe", log_fe[base], 1'b0);
    chk("t1_busy", Busy, 1'b0);
    lat = log_t[base] - start_cyc;
    chk("t1_strobe_in_stop_bit", (lat >= 10 * B) && (lat < 11 * B), 1'b1);

    // 2: 0x00 with wrong parity bit
    base = rx_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    bit_time(1'b1);
    chk("t2_cnt", rx_cnt, base + 1);
    chk("t2_dout", log_d[base], 8'h00);
    chk("t2_pe", log_pe[base], 1'b1);
    chk("t2_fe", log_fe[base], 1'b0);

    // 3: 0xA5, stop bit low, line low for three bit times
    base = rx_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    chk("t3_cnt", rx_cnt, base + 1);
    chk("t3_dout", log_d[base], 8'hA5);
    chk("t3_pe", log_pe[base], 1'b0);
    chk("t3_fe", log_fe[base], 1'b1);
    chk("t3_busy_low_line", Busy, 1'b1);
    Sin = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_busy_released", Busy, 1'b0);
    bit_time(1'b1);
    chk("t3_no_second", rx_cnt, base + 1);

    // 4: short low glitch shorter than half a bit
    base = rx_cnt;
    Sin = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_busy_start", Busy, 1'b1);
    @(negedge clk);
    Sin = 1'b1;
    repeat (H + 3) @(negedge clk);
    chk("t4_busy_idle", Busy, 1'b0);
    bit_time(1'b1);
    chk("t4_cnt", rx_cnt, base);
    chk("t4_dout_held", Dout, 8'hA5);
    chk("t4_fe_held", FrameErr, 1'b1);

    // 5: reset during data bit 4 of 0x3C, then 0x7E
    base = rx_cnt;
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    Sin = 1'b1;
    repeat (H) @(negedge clk);
    chk("t5_busy_data", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk_cleared("t5_reset");
    @(negedge clk);
    Reset = 1'b0;
    bit_time(1'b1);
    bit_time(1'b1);
    chk("t5_no_strobe", rx_cnt, base);
    send_frame(8'h7E, 1'b1, 1'b1);
    bit_time(1'b1);
    chk("t5_cnt", rx_cnt, base + 1);
    chk("t5_dout", log_d[base], 8'h7E);
    chk("t5_pe", log_pe[base], 1'b0);
    chk("t5_fe", log_fe[base], 1'b0);

    // 6: back-to-back 0x55, 0xAA with no idle gap
    base = rx_cnt;
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    bit_time(1'b1);
    chk("t6_cnt", rx_cnt, base + 2);
    chk("t6_dout0", log_d[base], 8'h55);
    chk("t6_dout1", log_d[base + 1], 8'hAA);
    chk("t6_err0", {log_pe[base], log_fe[base]}, 2'b00);
    chk("t6_err1", {log_pe[base + 1], log_fe[base + 1]}, 2'b00);
    chk("t6_busy", Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
